// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-write-port, async-read RAM.
// Optional power-up clear sweep enabled by defining RAM_ARB_INIT_EN.
module ram_port_arbiter #(
  parameter int unsigned               ADDR_WIDTH = 6,
  parameter int unsigned               DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0]                   req_we,
  input  logic [2*ADDR_WIDTH-1:0]      req_addr,
  input  logic [2*DATA_WIDTH-1:0]      req_wdata,
  output logic [1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         ram_write_en,
  output logic [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic [DATA_WIDTH-1:0]        ram_write_data,
  output logic [ADDR_WIDTH-1:0]        ram_read_addr,
  input  logic [DATA_WIDTH-1:0]        ram_read_data,
  output logic                         init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef RAM_ARB_INIT_EN
  localparam state_t                  RESET_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH-1:0]   CNT_ONE     = 1;
  logic [ADDR_WIDTH-1:0]              r_init_cnt;
`else
  localparam state_t                  RESET_STATE = ST_RUN;
`endif

  state_t                  r_state;
  logic                    r_init_done;
  logic                    r_last;
  logic [ADDR_WIDTH-1:0]   r_raddr;
  logic [1:0]              r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  logic                    w_in_init;
  logic                    w_gnt_any;
  logic                    w_gnt_idx;
  logic [1:0]              w_grant;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic                    w_wr;
  logic                    w_rd;

  assign w_in_init = (r_state == ST_INIT);

  // r_last holds the index granted most recently; a contested cycle goes to the other one
  always_comb begin
    w_gnt_any = (r_state == ST_RUN) && (req_valid != 2'b00);
    if (req_valid == 2'b11) w_gnt_idx = ~r_last;
    else                    w_gnt_idx = req_valid[1];
  end

  assign w_grant = w_gnt_any ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign w_addr  = w_gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign w_wdata = w_gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign w_wr    = w_gnt_any &  req_we[w_gnt_idx];
  assign w_rd    = w_gnt_any & ~req_we[w_gnt_idx];

  assign req_ready      = rst_n ? w_grant : 2'b00;
  assign ram_write_en   = rst_n & (w_in_init | w_wr);
  assign ram_write_data = w_in_init ? INIT_VALUE : w_wdata;
`ifdef RAM_ARB_INIT_EN
  assign ram_write_addr = w_in_init ? r_init_cnt : w_addr;
`else
  assign ram_write_addr = w_addr;
`endif
  assign ram_read_addr  = w_rd ? w_addr : r_raddr;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_init_done <= 1'b0;
      r_last      <= 1'b1;
      r_raddr     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
`ifdef RAM_ARB_INIT_EN
      r_init_cnt  <= '0;
`endif
    end else begin
      r_rsp_valid <= w_rd ? w_grant : 2'b00;
      if (w_rd) begin
        r_rsp_rdata <= ram_read_data;
        r_raddr     <= w_addr;
      end
      if (w_gnt_any) r_last <= w_gnt_idx;
`ifdef RAM_ARB_INIT_EN
      if (w_in_init) begin
        r_init_cnt <= r_init_cnt + CNT_ONE;
        if (r_init_cnt == '1) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
`else
      r_init_done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural async-read RAM.
// Define RAM_ARB_INIT_EN to also exercise the init sweep.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;

`ifdef RAM_ARB_INIT_EN
  localparam logic [63:0] EXP_ADDR5 = 64'h3;
`else
  localparam logic [63:0] EXP_ADDR5 = 64'hA5;
`endif

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_write_en;
  logic [AW-1:0]   ram_write_addr;
  logic [DW-1:0]   ram_write_data;
  logic [AW-1:0]   ram_read_addr;
  logic [DW-1:0]   ram_read_data;
  logic            init_done;

  logic [DW-1:0]   mem [64];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (64'h3)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .init_done      (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
  end
  assign ram_read_data = mem[ram_read_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; leaves the bench at the following negedge.
  task automatic op(input string tag, input logic [1:0] v, input logic [1:0] we,
                    input logic [5:0] a0, input logic [5:0] a1,
                    input logic [63:0] d0, input logic [63:0] d1,
                    input logic [1:0] exp_rdy, input logic [1:0] exp_rsp,
                    input logic [63:0] exp_rdata);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, "_wen"}, 64'(ram_write_en), 64'(|(we & exp_rdy)));
    @(posedge clk);
    #1;
    check({tag, "_rspv"}, 64'(rsp_valid), 64'(exp_rsp));
    if (exp_rsp != 2'b00) check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    @(negedge clk);
  endtask

  task automatic reset_assert();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    #1;
    check("rst_rdy",   64'(req_ready),    64'(2'b00));
    check("rst_wen",   64'(ram_write_en), 64'(0));
    check("rst_rspv",  64'(rsp_valid),    64'(2'b00));
    check("rst_rdata", rsp_rdata,         64'(0));
    check("rst_idone", 64'(init_done),    64'(0));
  endtask

  task automatic release_reset();
    req_valid = 2'b00;
    req_we    = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RAM_ARB_INIT_EN
    req_valid = 2'b11;
    #1;
    check("init_idone_low", 64'(init_done), 64'(0));
    for (int i = 0; i < 64; i++) begin
      check("init_rdy",   64'(req_ready),      64'(2'b00));
      check("init_wen",   64'(ram_write_en),   64'(1));
      check("init_waddr", 64'(ram_write_addr), 64'(i));
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    check("init_idone_high", 64'(init_done), 64'(1));
    @(negedge clk);
    op("init_rd17", 2'b10, 2'b00, 6'd0, 6'd17, 64'h0, 64'h0, 2'b10, 2'b10, 64'h3);
`else
    @(posedge clk);
    #1;
    check("idone_high", 64'(init_done), 64'(1));
    @(negedge clk);
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    req_addr  = '0;
    req_wdata = '0;
    reset_assert();
    @(negedge clk);
    release_reset();

    // write then read back same address
    op("t1_wr", 2'b01, 2'b01, 6'd5, 6'd0, 64'hA5, 64'h0, 2'b01, 2'b00, 64'h0);
    op("t1_rd", 2'b01, 2'b00, 6'd5, 6'd0, 64'h0,  64'h0, 2'b01, 2'b01, 64'hA5);

    // preload via requester 1 only, then contested reads alternate starting at req0
    op("t2_w1", 2'b10, 2'b10, 6'd0, 6'd1, 64'h0, 64'h11, 2'b10, 2'b00, 64'h0);
    op("t2_w2", 2'b10, 2'b10, 6'd0, 6'd2, 64'h0, 64'h22, 2'b10, 2'b00, 64'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) op("t2_rr", 2'b11, 2'b00, 6'd1, 6'd2, 64'h0, 64'h0, 2'b01, 2'b01, 64'h11);
      else            op("t2_rr", 2'b11, 2'b00, 6'd1, 6'd2, 64'h0, 64'h0, 2'b10, 2'b10, 64'h22);
    end

    // req1 alone three times, then contested goes to req0
    for (int i = 0; i < 3; i++)
      op("t3_solo", 2'b10, 2'b00, 6'd1, 6'd2, 64'h0, 64'h0, 2'b10, 2'b10, 64'h22);
    op("t3_both", 2'b11, 2'b00, 6'd1, 6'd2, 64'h0, 64'h0, 2'b01, 2'b01, 64'h11);

    // idle cycle: no grant, read address and response data hold
    op("idle", 2'b00, 2'b11, 6'd7, 6'd9, 64'h0, 64'h0, 2'b00, 2'b00, 64'h0);
    check("idle_raddr", 64'(ram_read_addr), 64'(1));
    check("idle_rdata", rsp_rdata, 64'h11);

    // reset while a response is showing
    op("t4_rd", 2'b10, 2'b00, 6'd0, 6'd2, 64'h0, 64'h0, 2'b10, 2'b10, 64'h22);
    check("t4_pending", 64'(rsp_valid), 64'(2'b10));
    reset_assert();
    @(negedge clk);
    release_reset();
    op("t4_first", 2'b11, 2'b00, 6'd5, 6'd2, 64'h0, 64'h0, 2'b01, 2'b01, EXP_ADDR5);

    // top and bottom address from different requesters, read back crosswise
    op("t6_w_a", 2'b11, 2'b11, 6'd63, 6'd0, 64'hD0D0, 64'hD1D1, 2'b10, 2'b00, 64'h0);
    op("t6_w_b", 2'b11, 2'b11, 6'd63, 6'd0, 64'hD0D0, 64'hD1D1, 2'b01, 2'b00, 64'h0);
    op("t6_r_a", 2'b11, 2'b00, 6'd0, 6'd63, 64'h0, 64'h0, 2'b10, 2'b10, 64'hD0D0);
    op("t6_r_b", 2'b11, 2'b00, 6'd0, 6'd63, 64'h0, 64'h0, 2'b01, 2'b01, 64'hD1D1);
    op("t6_r_62", 2'b01, 2'b00, 6'd5, 6'd0, 64'h0, 64'h0, 2'b01, 2'b01, EXP_ADDR5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
